// File: rtl/mw_stage_buf.sv
// MEM->WB pipeline register: 2-entry skid buffer with valid/ready handshake,
// flush, muxed writeback value, bubble-safe write enable and stall counter.
module mw_stage_buf #(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      memory_res_in,
    input  logic [DATA_W-1:0]      ALU_result_in,
    input  logic [SEL_W-1:0]       reg_writesel_in,
    input  logic                   reg_write_en_in,
    input  logic                   MemtoReg_in,
    input  logic                   PC_en_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      memory_res_out,
    output logic [DATA_W-1:0]      ALU_result_out,
    output logic [SEL_W-1:0]       reg_writesel_out,
    output logic                   reg_write_en_out,
    output logic                   MemtoReg_out,
    output logic                   PC_en_out,
    output logic [DATA_W-1:0]      wb_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [SEL_W-1:0]  sel;
        logic              we;
        logic              m2r;
        logic              pc_en;
    } ent_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam ent_t ENT_RST = '{mem: '0, alu: '0, sel: '0, we: 1'b0, m2r: 1'b0, pc_en: 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_t                 state_q, state_d;
    ent_t                   head_q, head_d;
    ent_t                   skid_q, skid_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             occ_q, occ_d;
    logic                   we_out_q, we_out_d;
    ent_t                   in_ent_c;
    logic                   accept_c;
    logic                   drain_c;

    assign in_ent_c = '{mem: memory_res_in, alu: ALU_result_in, sel: reg_writesel_in,
                        we: reg_write_en_in, m2r: MemtoReg_in, pc_en: PC_en_in};
    assign accept_c = in_valid & in_ready_q;
    assign drain_c  = out_valid_q & out_ready;

    // Next-state: head/skid movement, flush squash, stall counting, derived flags
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skid_d      = skid_q;
        stall_d     = stall_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        occ_d       = occ_q;
        we_out_d    = we_out_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    head_d  = in_ent_c;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (accept_c) begin
                    if (drain_c) begin
                        head_d = in_ent_c;
                    end else begin
                        skid_d  = in_ent_c;
                        state_d = ST_FULL;
                    end
                end else if (drain_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain_c) begin
                    head_d  = skid_q;
                    state_d = ST_HEAD;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Squash drops both entries but leaves the data fields untouched
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end

        if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        occ_d       = (state_d == ST_FULL) ? 2'd2 : ((state_d == ST_HEAD) ? 2'd1 : 2'd0);
        we_out_d    = head_d.we & out_valid_d;
    end

    // State register, falling edge to line up with the neighbouring pipeline registers
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_q      <= ENT_RST;
            skid_q      <= ENT_RST;
            stall_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            we_out_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            stall_q     <= stall_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
            we_out_q    <= we_out_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = out_valid_q;
    assign occupancy        = occ_q;
    assign stall_cycles     = stall_q;
    assign memory_res_out   = head_q.mem;
    assign ALU_result_out   = head_q.alu;
    assign reg_writesel_out = head_q.sel;
    assign reg_write_en_out = we_out_q;
    assign MemtoReg_out     = head_q.m2r;
    assign PC_en_out        = head_q.pc_en;
    assign wb_data          = head_q.m2r ? head_q.mem : head_q.alu;

endmodule

// File: tb/tb_mw_stage_buf.sv
// Randomised and directed bench for mw_stage_buf against a queue-based model.
module tb_mw_stage_buf;

    localparam int unsigned DW = 10;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [SW-1:0] sel;
        logic          we;
        logic          m2r;
        logic          pc;
    } ent_t;

    localparam ent_t RST_E = '{mem: '0, alu: '0, sel: '0, we: 1'b0, m2r: 1'b0, pc: 1'b1};

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] memory_res_in, ALU_result_in, memory_res_out, ALU_result_out, wb_data;
    logic [SW-1:0] reg_writesel_in, reg_writesel_out;
    logic          reg_write_en_in, MemtoReg_in, PC_en_in;
    logic          reg_write_en_out, MemtoReg_out, PC_en_out;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    ent_t          mq[$];
    ent_t          m_last = RST_E;
    logic [CW-1:0] m_stall = '0;

    always #5 clk = ~clk;

    mw_stage_buf #(.DATA_W(DW), .SEL_W(SW), .STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .memory_res_in(memory_res_in), .ALU_result_in(ALU_result_in),
        .reg_writesel_in(reg_writesel_in), .reg_write_en_in(reg_write_en_in),
        .MemtoReg_in(MemtoReg_in), .PC_en_in(PC_en_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .memory_res_out(memory_res_out), .ALU_result_out(ALU_result_out),
        .reg_writesel_out(reg_writesel_out), .reg_write_en_out(reg_write_en_out),
        .MemtoReg_out(MemtoReg_out), .PC_en_out(PC_en_out),
        .wb_data(wb_data), .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [DW-1:0] m, input logic [DW-1:0] a,
                                input logic [SW-1:0] s, input logic we, input logic m2r,
                                input logic pc);
        ent_t e;
        e = '{mem: m, alu: a, sel: s, we: we, m2r: m2r, pc: pc};
        return e;
    endfunction

    task automatic check_all();
        ent_t h;
        int   n;
        n = mq.size();
        h = (n > 0) ? mq[0] : m_last;
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("in_ready", 32'(in_ready), 32'(n < 2));
        chk("occupancy", 32'(occupancy), 32'(n));
        chk("memory_res_out", 32'(memory_res_out), 32'(h.mem));
        chk("ALU_result_out", 32'(ALU_result_out), 32'(h.alu));
        chk("reg_writesel_out", 32'(reg_writesel_out), 32'(h.sel));
        chk("reg_write_en_out", 32'(reg_write_en_out), 32'((n > 0) && h.we));
        chk("MemtoReg_out", 32'(MemtoReg_out), 32'(h.m2r));
        chk("PC_en_out", 32'(PC_en_out), 32'(h.pc));
        chk("wb_data", 32'(wb_data), 32'(h.m2r ? h.mem : h.alu));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    endtask

    // One clock: drive inputs, advance the model across the falling edge, then check
    task automatic step(input logic rst, input logic iv, input ent_t b, input logic ordy,
                        input logic fl, output logic acc);
        logic drn;
        reset           = rst;
        flush           = fl;
        in_valid        = iv;
        memory_res_in   = b.mem;
        ALU_result_in   = b.alu;
        reg_writesel_in = b.sel;
        reg_write_en_in = b.we;
        MemtoReg_in     = b.m2r;
        PC_en_in        = b.pc;
        out_ready       = ordy;
        acc = iv && (mq.size() < 2);
        drn = (mq.size() > 0) && ordy;
        @(negedge clk);
        if (rst) begin
            mq.delete();
            m_last  = RST_E;
            m_stall = '0;
            acc     = 1'b0;
        end else begin
            if ((mq.size() > 0) && !ordy && (m_stall != CMAX)) m_stall = m_stall + 1'b1;
            if (fl) begin
                mq.delete();
                acc = 1'b0;
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(b);
            end
            if (mq.size() > 0) m_last = mq[0];
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        ent_t a, b, c, d, pend;
        logic acc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        memory_res_in = '0; ALU_result_in = '0; reg_writesel_in = '0;
        reg_write_en_in = 1'b0; MemtoReg_in = 1'b0; PC_en_in = 1'b0;

        // reset
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);

        // single entry, ALU writeback
        step(1'b0, 1'b1, mk(10'h001, 10'h003, 3'd2, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, acc);
        chk("t2_wb_data", 32'(wb_data), 32'h003);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

        // fill under backpressure, third push refused
        a = mk(10'h011, 10'h00A, 3'd1, 1'b1, 1'b0, 1'b1);
        b = mk(10'h022, 10'h00B, 3'd3, 1'b1, 1'b0, 1'b0);
        c = mk(10'h033, 10'h00C, 3'd4, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, a, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, b, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, c, 1'b0, 1'b0, acc);
        chk("t3_c_refused", 32'(acc), 32'(0));
        step(1'b0, 1'b1, c, 1'b0, 1'b0, acc);

        // release: A, B, C in order
        step(1'b0, 1'b1, c, 1'b1, 1'b0, acc);
        chk("t4_head_b", 32'(ALU_result_out), 32'h00B);
        step(1'b0, 1'b1, c, 1'b1, 1'b0, acc);
        chk("t4_head_c", 32'(ALU_result_out), 32'h00C);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

        // flush with two held plus a concurrent push
        d = mk(10'h155, 10'h2AA, 3'd7, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, a, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, b, 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, d, 1'b1, 1'b1, acc);
        chk("t5_flushed_empty", 32'(occupancy), 32'(0));
        step(1'b0, 1'b0, d, 1'b1, 1'b0, acc);

        // memory writeback, then long stall to saturate the counter
        step(1'b0, 1'b1, mk(10'h3FF, 10'h002, 3'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, acc);
        chk("t6_wb_mem", 32'(wb_data), 32'h3FF);
        for (int i = 0; i < (1 << CW) + 5; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        chk("t6_saturated", 32'(stall_cycles), 32'(CMAX));
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

        // random traffic with rare flush and reset
        pend = ent_t'(26'($urandom));
        for (int i = 0; i < 3000; i++) begin
            logic iv, ordy, fl, rst;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 40) == 0);
            rst  = ($urandom_range(0, 700) == 0);
            step(rst, iv, pend, ordy, fl, acc);
            if (acc) pend = ent_t'(26'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mw_stage_buf.md
Name: mw_stage_buf

Overview:
Parametrised successor to the memory→writeback pipeline register. It carries the MEM-stage result bundle (memory data, ALU result, destination select, write enable, MemtoReg, PC enable) to writeback. It adds a 2-entry skid buffer with valid/ready handshake, synchronous flush, a muxed writeback value, a bubble-safe write enable and a saturating stall-cycle counter. It sits between the data cache/MEM stage and the register-file write port.

Parameters:
DATA_W, 10, width of memory data, ALU result and writeback data
SEL_W, 3, width of destination register select
STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock; all state updates on the falling edge of clk, matching the other pipeline registers
reset  in  1  synchronous, active-high reset
flush  in  1  drop all buffered entries (branch/exception squash)
in_valid  in  1  upstream bundle valid
in_ready  out  1  buffer can accept; registered
memory_res_in  in  DATA_W  data read from cache
ALU_result_in  in  DATA_W  ALU result
reg_writesel_in  in  SEL_W  destination register
reg_write_en_in  in  1  register write enable
MemtoReg_in  in  1  1 = write back memory data
PC_en_in  in  1  PC enable passed through
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts (cache_Ready)
memory_res_out  out  DATA_W  head-entry memory data
ALU_result_out  out  DATA_W  head-entry ALU result
reg_writesel_out  out  SEL_W  head-entry destination
reg_write_en_out  out  1  head write enable AND out_valid
MemtoReg_out  out  1  head MemtoReg
PC_en_out  out  1  head PC enable
wb_data  out  DATA_W  MemtoReg_out ? memory_res_out : ALU_result_out
occupancy  out  2  entries held: 0, 1 or 2
stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: head register (drives the outputs) and skid register. Each has its own valid bit.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready = !skid_valid, taken from the register (no combinational path from out_ready).
- Per edge, with skid empty:
  - head empty, or Drain: an accepted input loads head.
  - head full and no Drain: an accepted input loads skid.
  - Drain with no Accept: head goes empty.
- Per edge, with skid full (no Accept is possible):
  - Drain: skid moves to head; skid goes empty.
  - No Drain: hold.
- Latency: 1 edge from Accept to out_valid when the buffer is empty. Order is strictly FIFO. A 1-entry-per-cycle stream runs at full throughput while out_ready=1.
- flush (reset=0): both valid bits clear at the next edge. An Accept and a Drain in the same cycle are both discarded, i.e. no new entry is stored. Data fields hold their values. in_ready=1 from the next cycle.
- reset has priority over flush. Reset mid-transfer discards everything.
- Reset values:
  - out_valid=0, occupancy=0, in_ready=1, stall_cycles=0.
  - All data and select outputs are 0. reg_write_en_out=0, MemtoReg_out=0.
  - PC_en_out=1.
- Bubble safety: reg_write_en_out is forced to 0 whenever out_valid=0. Other fields show the last head contents.
- wb_data is purely combinational from the head fields.
- occupancy = head_valid + skid_valid.
- stall_cycles increments on each edge where out_valid=1 & out_ready=0. It saturates at all-ones and clears only on reset; flush does not clear it.
- A simultaneous Accept and Drain with one entry held keeps occupancy at 1; the head takes the new entry.

Test Plan:
1. Reset 2 cycles → out_valid=0, in_ready=1, PC_en_out=1, all data outputs 0, stall_cycles=0.
2. out_ready=1; send memory_res_in=0x001, ALU_result_in=0x003, reg_writesel_in=2, reg_write_en_in=1, MemtoReg_in=0 → next edge: out_valid=1, wb_data=0x003, reg_write_en_out=1, occupancy=1.
3. out_ready=0; push A (ALU 0x00A) then B (ALU 0x00B) → occupancy=2, in_ready=0, head=A. Then a third push C is refused, C is held upstream, and stall_cycles increments each edge.
4. Release out_ready=1 → A, then B, then C appear on consecutive edges in order. in_ready returns to 1 one edge after skid drains.
5. occupancy=2 with flush=1 and in_valid=1 in the same cycle → next edge: out_valid=0, occupancy=0, reg_write_en_out=0, in_ready=1. The flushed-cycle input never appears.
6. Entry with MemtoReg_in=1, memory_res_in=0x3FF, ALU 0x002 → wb_data=0x3FF. Separately, hold a stall for 2^STALL_CNT_W+5 cycles → stall_cycles stays at all-ones.
